platform_nios_oci_dct_ctrl: RTL and testbench
=============================================

Name: platform_nios_oci_dct_ctrl

Overview:
- Sequencing controller for the Nios OCI compressed-trace (DCT) buffer.
- Packs 2-bit trace atoms from the CPU trace encoder into a 30-bit DCT buffer and tracks the fill with a 4-bit atom count.
- Hands completed or flushed frames to the trace FIFO over a valid/ready handshake.
- Double-buffered: one accumulator plus one output frame register, so capture continues while a frame waits for the FIFO.

Parameters:
- ATOM_W, 2, bits per trace atom.
- ATOMS, 15, atoms per frame; buffer width = ATOM_W*ATOMS = 30.
- CNT_W, 4, count width; must hold ATOMS.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- trc_on  input  1  trace enable; atoms are ignored while low.
- atom_valid  input  1  atom strobe, one atom per cycle.
- atom_data  input  2  atom payload.
- flush  input  1  single-cycle request to emit a partial frame.
- ovf_clr  input  1  clears the sticky overflow flag.
- frame_valid  output  1  output frame present.
- frame_ready  input  1  FIFO accepts the frame.
- frame_data  output  30  packed frame.
- frame_count  output  4  valid atoms in frame_data, 1..15.
- dct_buffer  output  30  live accumulator contents.
- dct_count  output  4  live accumulator atom count, 0..15.
- overflow  output  1  sticky: an atom was dropped.

Behaviour:
- Reset (asynchronous, reset_n low), all outputs and state cleared:
  - dct_buffer=0, dct_count=0, frame_valid=0, frame_data=0, frame_count=0, overflow=0.
  - flush_pend=0.
  - FSM returns to FILL.
  - Reset mid-frame discards both the accumulator and any held frame.
- Atom accept: requires atom_valid & trc_on.
  - Atom is written to dct_buffer[2k+1:2k] with k=dct_count; dct_count increments.
  - Bits above slot k stay 0.
- Output slot is free when frame_valid=0 or frame_ready=1 in the same cycle.
- Commit moves the accumulator into the output register:
  - frame_data<=dct_buffer, frame_count<=dct_count, frame_valid<=1.
  - dct_buffer<=0, dct_count<=0.
  - An atom accepted in the commit cycle lands in slot 0 of the fresh accumulator (dct_count becomes 1) and is never part of the committed frame.
- Accumulator FSM:
  - FILL: accepts atoms. The 15th atom moves to FULL.
  - FILL with flush_pend=1 and dct_count>0: commit when the slot is free, clear flush_pend, stay in FILL.
  - FULL: commit when the slot is free, then return to FILL.
  - FULL with slot not free and an atom accepted: atom dropped, overflow<=1, state and buffer unchanged.
- Latency:
  - 15th atom sampled at edge N → dct_count=15 after N → commit at edge N+1 if the slot is free → frame_valid high after N+1.
  - This gives one cycle of FULL with an empty output.
- Flush:
  - flush sets flush_pend.
  - With dct_count=0 and not FULL, flush_pend clears immediately and no frame is emitted.
  - flush while FULL is absorbed by the normal full commit.
  - flush arriving in the same cycle as a commit applies to the new accumulator, including a slot-0 atom accepted that cycle.
- trc_on falling edge (registered) acts as an implicit flush.
- Handshake:
  - frame_valid drops after a cycle with frame_ready=1, unless a commit occurs in that same cycle; then frame_valid stays 1 with the new data.
  - frame_data and frame_count are stable while frame_valid=1 and frame_ready=0.
- overflow: ovf_clr clears it. A drop in the same cycle as ovf_clr wins, so overflow=1.
- dct_buffer and dct_count are registered status outputs, never cleared except by commit or reset.

Optional Feature:
- Macro: DCT_FRAME_SEQ_EN.
- Defined:
  - Adds output frame_seq[3:0], reset 0, loaded with an internal sequence counter on every commit.
  - The counter increments per commit and wraps 15→0.
  - Dropped atoms do not advance the counter.
- Undefined: no frame_seq port and no counter; all other behaviour is identical.

Test Plan:
- Fill: 15 back-to-back atoms of value 2'b01, frame_ready=1 → exactly one frame, frame_data=30'h15555555, frame_count=15, frame_valid high for 1 cycle, dct_count returns 0.
- Partial flush: 3 atoms 2'b11,2'b10,2'b01, then flush → frame_data=30'h0000001B, frame_count=3. A second flush with an empty accumulator → no frame.
- Backpressure/overflow:
  - frame_ready=0, 31 atoms → first frame held stable, accumulator FULL, 31st atom dropped, overflow=1.
  - Raise frame_ready → second frame commits.
  - ovf_clr → overflow=0.
- Commit-cycle atom: 16 consecutive atoms with frame_ready=1 → atom 16 appears in dct_buffer[1:0] with dct_count=1, absent from frame 1.
- trc_on drop: 5 atoms then trc_on 1→0 → frame_count=5 emitted. Atoms while trc_on=0 are ignored (dct_count stays 0).
- Async reset: assert reset_n low mid-fill with a held frame → all outputs 0 immediately, no frame after release. With DCT_FRAME_SEQ_EN: 17 commits → frame_seq sequence 0..15,0.

Source files
------------

// File: rtl/platform_nios_oci_dct_ctrl.sv
// platform_nios_oci_dct_ctrl
//   Sequencing controller for the Nios OCI compressed-trace (DCT) buffer.
//   2-bit trace atoms are packed into a 30-bit accumulator, slot k at bits
//   [2k+1:2k]. Completed (15 atoms) or flushed frames are committed into a
//   separate output frame register and offered to the trace FIFO over a
//   valid/ready handshake. This lets capture continue while a frame waits
//   for the FIFO.
//
// Ports
//   clk, reset_n             rising-edge clock, asynchronous active-low reset
//   trc_on                   trace enable; its registered falling edge flushes
//   atom_valid, atom_data    atom strobe and payload
//   flush                    single-cycle request to emit a partial frame
//   ovf_clr                  clears the sticky overflow flag
//   frame_valid/ready        output handshake
//   frame_data, frame_count  held frame and its atom count (1..15)
//   dct_buffer, dct_count    live accumulator contents and atom count
//   overflow                 sticky: an atom was dropped while FULL
//   frame_seq                (DCT_FRAME_SEQ_EN only) per-commit sequence number
//
// Optional feature macro: DCT_FRAME_SEQ_EN
module platform_nios_oci_dct_ctrl #(
  parameter int unsigned ATOM_W = 2,
  parameter int unsigned ATOMS  = 15,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      trc_on,
  input  logic                      atom_valid,
  input  logic [ATOM_W-1:0]         atom_data,
  input  logic                      flush,
  input  logic                      ovf_clr,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic [ATOM_W*ATOMS-1:0]   frame_data,
  output logic [CNT_W-1:0]          frame_count,
  output logic [ATOM_W*ATOMS-1:0]   dct_buffer,
  output logic [CNT_W-1:0]          dct_count,
`ifdef DCT_FRAME_SEQ_EN
  output logic [3:0]                frame_seq,
`endif
  output logic                      overflow
);

  localparam int unsigned BUF_W = ATOM_W * ATOMS;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;
  logic             trc_on_q;
  logic             fvalid_q, fvalid_d;
  logic [BUF_W-1:0] fdata_q, fdata_d;
  logic [CNT_W-1:0] fcount_q, fcount_d;
  logic             ovf_q, ovf_d;

  logic slot_free;
  logic accept;
  logic trc_fall;
  logic commit;
  logic drop;
  logic clear_pend;

`ifdef DCT_FRAME_SEQ_EN
  logic [3:0] seq_cnt_q, seq_cnt_d;
  logic [3:0] fseq_q, fseq_d;
`endif

  always_comb begin
    slot_free = !fvalid_q || frame_ready;
    accept    = atom_valid && trc_on;
    trc_fall  = trc_on_q && !trc_on;

    commit = 1'b0;
    drop   = 1'b0;
    if (state_q == ST_FILL) begin
      if (flush_pend_q && (cnt_q != '0) && slot_free) commit = 1'b1;
    end else begin
      if (slot_free)   commit = 1'b1;
      else if (accept) drop   = 1'b1;
    end

    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    if (commit) begin
      // An atom arriving with the commit starts the fresh accumulator.
      state_d = ST_FILL;
      buf_d   = '0;
      cnt_d   = '0;
      if (accept) begin
        buf_d[ATOM_W-1:0] = atom_data;
        cnt_d             = CNT_W'(1);
      end
    end else if ((state_q == ST_FILL) && accept) begin
      for (int unsigned i = 0; i < ATOMS; i++) begin
        if (CNT_W'(i) == cnt_q) buf_d[i*ATOM_W +: ATOM_W] = atom_data;
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(ATOMS - 1)) state_d = ST_FULL;
    end

    // A pending flush is consumed by any commit (including a FULL commit) or
    // dropped when there is nothing to emit. A new request arriving in the
    // same cycle re-arms it for the fresh accumulator.
    clear_pend   = commit || ((state_q == ST_FILL) && (cnt_q == '0));
    flush_pend_d = (flush_pend_q && !clear_pend) || flush || trc_fall;

    fvalid_d = fvalid_q;
    fdata_d  = fdata_q;
    fcount_d = fcount_q;
    if (commit) begin
      fvalid_d = 1'b1;
      fdata_d  = buf_q;
      fcount_d = cnt_q;
    end else if (frame_ready) begin
      fvalid_d = 1'b0;
    end

    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;

`ifdef DCT_FRAME_SEQ_EN
    seq_cnt_d = seq_cnt_q;
    fseq_d    = fseq_q;
    if (commit) begin
      fseq_d    = seq_cnt_q;
      seq_cnt_d = seq_cnt_q + 4'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_FILL;
      buf_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      trc_on_q     <= 1'b0;
      fvalid_q     <= 1'b0;
      fdata_q      <= '0;
      fcount_q     <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      trc_on_q     <= trc_on;
      fvalid_q     <= fvalid_d;
      fdata_q      <= fdata_d;
      fcount_q     <= fcount_d;
      ovf_q        <= ovf_d;
    end
  end

`ifdef DCT_FRAME_SEQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_cnt_q <= '0;
      fseq_q    <= '0;
    end else begin
      seq_cnt_q <= seq_cnt_d;
      fseq_q    <= fseq_d;
    end
  end

  assign frame_seq = fseq_q;
`endif

  assign frame_valid = fvalid_q;
  assign frame_data  = fdata_q;
  assign frame_count = fcount_q;
  assign dct_buffer  = buf_q;
  assign dct_count   = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_platform_nios_oci_dct_ctrl.sv
// Directed self-checking bench for platform_nios_oci_dct_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_platform_nios_oci_dct_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trc_on;
  logic        atom_valid;
  logic [1:0]  atom_data;
  logic        flush;
  logic        ovf_clr;
  logic        frame_valid;
  logic        frame_ready;
  logic [29:0] frame_data;
  logic [3:0]  frame_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
`ifdef DCT_FRAME_SEQ_EN
  logic [3:0]  frame_seq;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  platform_nios_oci_dct_ctrl #(.ATOM_W(2), .ATOMS(15), .CNT_W(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .trc_on      (trc_on),
    .atom_valid  (atom_valid),
    .atom_data   (atom_data),
    .flush       (flush),
    .ovf_clr     (ovf_clr),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_count (frame_count),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
`ifdef DCT_FRAME_SEQ_EN
    .frame_seq   (frame_seq),
`endif
    .overflow    (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic atom(input logic [1:0] d);
    atom_valid = 1'b1;
    atom_data  = d;
    step();
    atom_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; trc_on = 1'b0; atom_valid = 1'b0; atom_data = 2'b00;
    flush = 1'b0; ovf_clr = 1'b0; frame_ready = 1'b0;
    step(); step();
    checks++;
    if (frame_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags: valid=%b ovf=%b required 0 0", frame_valid, overflow);
    end
    checks++;
    if (dct_buffer !== 30'h0 || dct_count !== 4'd0) begin
      errors++; $display("FAIL reset_acc: buf=%h cnt=%0d required 0 0", dct_buffer, dct_count);
    end
    checks++;
    if (frame_data !== 30'h0 || frame_count !== 4'd0) begin
      errors++; $display("FAIL reset_frame: data=%h cnt=%0d required 0 0", frame_data, frame_count);
    end
    reset_n = 1'b1;
    trc_on  = 1'b1;
    step();
  endtask

  task automatic test_fill();
    int vcnt = 0;
    frame_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      atom(2'b01);
      if (frame_valid === 1'b1) vcnt++;
    end
    checks++;
    if (dct_count !== 4'd15) begin
      errors++; $display("FAIL fill_count15: got %0d required 15", dct_count);
    end
    step();
    if (frame_valid === 1'b1) vcnt++;
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== 30'h15555555 || frame_count !== 4'd15) begin
      errors++; $display("FAIL fill_frame: valid=%b data=%h cnt=%0d required 1 15555555 15",
                         frame_valid, frame_data, frame_count);
    end
    checks++;
    if (dct_count !== 4'd0 || dct_buffer !== 30'h0) begin
      errors++; $display("FAIL fill_acc_clear: cnt=%0d buf=%h required 0 0", dct_count, dct_buffer);
    end
    step();
    if (frame_valid === 1'b1) vcnt++;
    checks++;
    if (vcnt != 1) begin
      errors++; $display("FAIL fill_one_frame: valid cycles=%0d required 1", vcnt);
    end
  endtask

  task automatic test_partial_flush();
    int vcnt = 0;
    frame_ready = 1'b1;
    atom(2'b11); atom(2'b10); atom(2'b01);
    flush = 1'b1; step(); flush = 1'b0;
    step();
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== 30'h0000001B || frame_count !== 4'd3) begin
      errors++; $display("FAIL partial_frame: valid=%b data=%h cnt=%0d required 1 0000001b 3",
                         frame_valid, frame_data, frame_count);
    end
    step();
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++; $display("FAIL partial_drop_valid: got %b required 0", frame_valid);
    end
    flush = 1'b1; step(); flush = 1'b0;
    if (frame_valid === 1'b1) vcnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (frame_valid === 1'b1) vcnt++;
    end
    checks++;
    if (vcnt != 0 || dct_count !== 4'd0) begin
      errors++; $display("FAIL empty_flush: valid cycles=%0d cnt=%0d required 0 0", vcnt, dct_count);
    end
  endtask

  task automatic test_overflow();
    int unstable = 0;
    frame_ready = 1'b0;
    for (int i = 0; i < 15; i++) atom(2'b10);
    atom(2'b11);
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== 30'h2AAAAAAA || dct_count !== 4'd1) begin
      errors++; $display("FAIL ovf_first_commit: valid=%b data=%h cnt=%0d required 1 2aaaaaaa 1",
                         frame_valid, frame_data, dct_count);
    end
    for (int i = 0; i < 14; i++) begin
      atom(2'b11);
      if (frame_valid !== 1'b1 || frame_data !== 30'h2AAAAAAA || frame_count !== 4'd15) unstable++;
    end
    atom(2'b01);
    if (frame_valid !== 1'b1 || frame_data !== 30'h2AAAAAAA || frame_count !== 4'd15) unstable++;
    checks++;
    if (unstable != 0) begin
      errors++; $display("FAIL ovf_hold_stable: unstable cycles=%0d required 0", unstable);
    end
    checks++;
    if (overflow !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== 30'h3FFFFFFF) begin
      errors++; $display("FAIL ovf_drop: ovf=%b cnt=%0d buf=%h required 1 15 3fffffff",
                         overflow, dct_count, dct_buffer);
    end
    frame_ready = 1'b1;
    step();
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== 30'h3FFFFFFF || frame_count !== 4'd15 || dct_count !== 4'd0) begin
      errors++; $display("FAIL ovf_second_commit: valid=%b data=%h fcnt=%0d cnt=%0d required 1 3fffffff 15 0",
                         frame_valid, frame_data, frame_count, dct_count);
    end
    step();
    checks++;
    if (frame_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: valid=%b ovf=%b required 0 1", frame_valid, overflow);
    end
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b required 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    frame_ready = 1'b1;
    for (int i = 0; i < 15; i++) atom(2'b01);
    atom(2'b11);
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== 30'h15555555 || frame_count !== 4'd15) begin
      errors++; $display("FAIL b2b_frame: valid=%b data=%h cnt=%0d required 1 15555555 15",
                         frame_valid, frame_data, frame_count);
    end
    checks++;
    if (dct_buffer !== 30'h00000003 || dct_count !== 4'd1) begin
      errors++; $display("FAIL b2b_slot0: buf=%h cnt=%0d required 00000003 1", dct_buffer, dct_count);
    end
    flush = 1'b1; step(); flush = 1'b0;
    step();
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== 30'h00000003 || frame_count !== 4'd1) begin
      errors++; $display("FAIL b2b_tail: valid=%b data=%h cnt=%0d required 1 00000003 1",
                         frame_valid, frame_data, frame_count);
    end
    step();
  endtask

  task automatic test_trc_drop();
    frame_ready = 1'b1;
    for (int i = 0; i < 5; i++) atom(2'b10);
    trc_on = 1'b0;
    step();
    step();
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== 30'h000002AA || frame_count !== 4'd5) begin
      errors++; $display("FAIL trc_drop_frame: valid=%b data=%h cnt=%0d required 1 000002aa 5",
                         frame_valid, frame_data, frame_count);
    end
    for (int i = 0; i < 3; i++) atom(2'b11);
    checks++;
    if (dct_count !== 4'd0 || frame_valid !== 1'b0) begin
      errors++; $display("FAIL trc_off_ignore: cnt=%0d valid=%b required 0 0", dct_count, frame_valid);
    end
    trc_on = 1'b1;
    step();
  endtask

  task automatic test_async_reset();
    int vcnt = 0;
    frame_ready = 1'b0;
    for (int i = 0; i < 19; i++) atom(2'b01);
    checks++;
    if (frame_valid !== 1'b1 || dct_count !== 4'd4) begin
      errors++; $display("FAIL rst_setup: valid=%b cnt=%0d required 1 4", frame_valid, dct_count);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (frame_valid !== 1'b0 || frame_data !== 30'h0 || frame_count !== 4'd0 ||
        dct_buffer !== 30'h0 || dct_count !== 4'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL async_reset: valid=%b data=%h fcnt=%0d buf=%h cnt=%0d ovf=%b required all 0",
                         frame_valid, frame_data, frame_count, dct_buffer, dct_count, overflow);
    end
    #3 reset_n = 1'b1;
    frame_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (frame_valid === 1'b1) vcnt++;
    end
    checks++;
    if (vcnt != 0 || dct_count !== 4'd0) begin
      errors++; $display("FAIL rst_no_frame: valid cycles=%0d cnt=%0d required 0 0", vcnt, dct_count);
    end
  endtask

`ifdef DCT_FRAME_SEQ_EN
  task automatic test_frame_seq();
    int bad = 0;
    logic [3:0] exp_seq;
    frame_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      atom_valid = 1'b1; atom_data = 2'b01; flush = 1'b1;
      step();
      atom_valid = 1'b0; flush = 1'b0;
      step();
      exp_seq = 4'(i);
      if (frame_valid !== 1'b1 || frame_seq !== exp_seq) begin
        bad++;
        $display("FAIL frame_seq_%0d: valid=%b seq=%0d required 1 %0d", i, frame_valid, frame_seq, exp_seq);
      end
    end
    checks++;
    if (bad != 0) errors++;
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_partial_flush();
    test_overflow();
    test_back_to_back();
    test_trc_drop();
    test_async_reset();
`ifdef DCT_FRAME_SEQ_EN
    test_frame_seq();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
